// File: rtl/data_mem_io_if.sv
// data_mem_io_if: core load/store bus, TX stream and GPIO pins of the data memory system.
interface data_mem_io_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] gpio_out;
    modport slave (input MemWrite, ALUResult, WriteData, tx_ready,
                   output ReadData, tx_data, tx_valid, gpio_out);
    modport master (output MemWrite, ALUResult, WriteData, tx_ready,
                    input ReadData, tx_data, tx_valid, gpio_out);
endinterface

// File: rtl/data_mem_io.sv
// data_mem_io: word RAM plus IO page (GPIO, cycle counter, TX FIFO) with combinational reads.
module data_mem_io #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] GPIO_RESET = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    data_mem_io_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] SEL_GPIO = 2'd0;
    localparam logic [1:0] SEL_TX   = 2'd1;
    localparam logic [1:0] SEL_CYC  = 2'd2;
    localparam logic [1:0] SEL_STAT = 2'd3;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd, r_wr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_gpio, r_cycles;
    logic          r_ovf;

    logic          w_io, w_io_we, w_ram_we, w_push, w_pop, w_accept, w_full, w_empty;
    logic [1:0]    w_sel, w_cnt;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_head, w_status;

    assign w_io     = bus.ALUResult[31];
    assign w_sel    = bus.ALUResult[3:2];
    assign w_idx    = bus.ALUResult[AW+1:2];
    assign w_io_we  = bus.MemWrite & w_io;
    assign w_ram_we = bus.MemWrite & ~w_io;
    assign w_empty  = r_count == '0;
    assign w_full   = r_count == CW'(FIFO_DEPTH);
    assign w_pop    = ~w_empty & bus.tx_ready;
    assign w_push   = w_io_we & (w_sel == SEL_TX);
    // A full FIFO still takes a push when the head leaves on the same edge
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_head   = w_empty ? '0 : r_fifo[r_rd];
    assign w_cnt    = (FIFO_DEPTH == 4 || r_count <= CW'(3)) ? r_count[1:0] : 2'd3;
    assign w_status = {27'b0, r_ovf, w_full, w_empty, w_cnt};

    assign bus.ReadData = ~w_io                ? r_ram[w_idx] :
                          w_sel == SEL_GPIO    ? r_gpio :
                          w_sel == SEL_TX      ? w_head :
                          w_sel == SEL_CYC     ? r_cycles : w_status;
    assign bus.tx_data  = w_head;
    assign bus.tx_valid = ~w_empty;
    assign bus.gpio_out = r_gpio;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio   <= GPIO_RESET;
            r_cycles <= '0;
            r_ovf    <= 1'b0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
        end else begin
            r_cycles <= (w_io_we && w_sel == SEL_CYC) ? '0 : r_cycles + 32'd1;
            if (w_io_we && w_sel == SEL_GPIO) r_gpio <= bus.WriteData;
            if (w_io_we && w_sel == SEL_STAT && bus.WriteData[4]) r_ovf <= 1'b0;
            else if (w_push && !w_accept) r_ovf <= 1'b1;
            if (w_accept) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(w_accept) - CW'(w_pop);
        end
    end

    // Storage arrays are never reset; a stale FIFO slot is masked by r_count
    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_idx] <= bus.WriteData;
        if (w_accept) r_fifo[r_wr] <= bus.WriteData;
    end
endmodule

// File: tb/tb_data_mem_io.sv
// tb_data_mem_io: directed and random checks of data_mem_io against a queue/array reference model.
module tb_data_mem_io;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_io_if bus ();
    data_mem_io dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_mem [64];
    bit          m_known [64];
    logic [31:0] m_gpio, m_cyc;
    logic [31:0] m_q [$];
    bit          m_ovf;
    logic [31:0] exp4 [4];

    function automatic logic [31:0] m_read(logic [31:0] a);
        int ix = int'((a >> 2) % 64);
        int sel = int'((a >> 2) % 4);
        int n = m_q.size();
        if (!a[31]) return m_mem[ix];
        if (sel == 0) return m_gpio;
        if (sel == 1) return n > 0 ? m_q[0] : 32'd0;
        if (sel == 2) return m_cyc;
        return {27'b0, m_ovf, n == 4, n == 0, 2'(n % 4)};
    endfunction

    task automatic model_edge(bit we, logic [31:0] a, logic [31:0] d, bit rdy);
        int ix = int'((a >> 2) % 64);
        int sel = int'((a >> 2) % 4);
        bit io = a[31];
        bit pop = m_q.size() > 0 && rdy;
        bit push = we && io && sel == 1;
        bit acc = push && (m_q.size() < 4 || pop);
        m_cyc = (we && io && sel == 2) ? 32'd0 : m_cyc + 32'd1;
        if (we && io && sel == 0) m_gpio = d;
        if (we && io && sel == 3 && d[4]) m_ovf = 0;
        if (push && !acc) m_ovf = 1;
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        if (we && !io) begin
            m_mem[ix] = d;
            m_known[ix] = 1;
        end
    endtask

    task automatic m_reset();
        m_gpio = 32'd0;
        m_cyc = 32'd0;
        m_ovf = 0;
        m_q.delete();
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(bit we, logic [31:0] a, logic [31:0] d, bit rdy);
        bus.MemWrite = we;
        bus.ALUResult = a;
        bus.WriteData = d;
        bus.tx_ready = rdy;
        #1;
        if (a[31] || m_known[int'((a >> 2) % 64)]) chk("rdata", bus.ReadData, m_read(a));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
        chk("tx_data", bus.tx_data, m_q.size() != 0 ? m_q[0] : 32'd0);
        chk("gpio", bus.gpio_out, m_gpio);
        @(posedge clk);
        if (reset) model_edge(we, a, d, rdy);
        @(negedge clk);
    endtask

    task automatic peek(logic [31:0] a, logic [31:0] exp, string tag);
        bus.MemWrite = 1'b0;
        bus.ALUResult = a;
        #1;
        chk(tag, bus.ReadData, exp);
    endtask

    initial begin
        bus.MemWrite = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        bus.tx_ready = 1'b0;
        m_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gpio", bus.gpio_out, 32'd0);
        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_txdata", bus.tx_data, 32'd0);
        peek(32'h8000_0008, 32'd0, "rst_cycles");
        reset = 1'b1;
        repeat (10) step(0, 32'h8000_0000, 0, 0);
        peek(32'h8000_0008, 32'd10, "cyc10");
        step(1, 32'h8000_0008, 32'h1234, 0);
        peek(32'h8000_0008, 32'd0, "cyc_clr");
        step(0, 32'h8000_0000, 0, 0);
        peek(32'h8000_0008, 32'd1, "cyc_after_clr");
        step(1, 32'h10, 32'hDEAD_BEEF, 0);
        peek(32'h10, 32'hDEAD_BEEF, "ram_rd");
        peek(32'h110, 32'hDEAD_BEEF, "ram_alias");
        step(1, 32'h10, 32'h1234_5678, 0);
        peek(32'h10, 32'h1234_5678, "ram_new");
        step(1, 32'h10, 32'hDEAD_BEEF, 0);
        step(1, 32'h8000_0000, 32'hA5, 0);
        chk("gpio_a5", bus.gpio_out, 32'hA5);
        peek(32'h8000_0000, 32'hA5, "gpio_rd");
        for (int i = 1; i <= 5; i++) step(1, 32'h8000_0004, i, 0);
        peek(32'h8000_000C, 32'h18, "stat_full_ovf");
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", 32'(bus.tx_valid), 32'd1);
            chk("drain_data", bus.tx_data, i);
            step(0, 32'h8000_0000, 0, 1);
        end
        chk("drained", 32'(bus.tx_valid), 32'd0);
        step(1, 32'h8000_000C, 32'h10, 0);
        peek(32'h8000_000C, 32'h04, "stat_ovf_clr");
        for (int i = 10; i <= 13; i++) step(1, 32'h8000_0004, i, 0);
        step(1, 32'h8000_0004, 32'd9, 1);
        peek(32'h8000_000C, 32'h08, "stat_full_noovf");
        exp4 = '{32'd11, 32'd12, 32'd13, 32'd9};
        for (int i = 0; i < 4; i++) begin
            chk("pushpop_data", bus.tx_data, exp4[i]);
            step(0, 32'h8000_0000, 0, 1);
        end
        chk("pushpop_empty", 32'(bus.tx_valid), 32'd0);
        step(1, 32'h8000_0000, 32'h55, 0);
        for (int i = 20; i <= 22; i++) step(1, 32'h8000_0004, i, 0);
        step(0, 32'h8000_0000, 0, 1);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.tx_valid), 32'd0);
        chk("arst_gpio", bus.gpio_out, 32'd0);
        m_reset();
        step(1, 32'h8000_0000, 32'h77, 0);
        chk("arst_store_lost", bus.gpio_out, 32'd0);
        reset = 1'b1;
        peek(32'h10, 32'hDEAD_BEEF, "ram_kept");
        repeat (400) begin
            logic [31:0] ra;
            ra = $urandom;
            ra[31] = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 3) == 0) ra[3:2] = 2'd1;
            step($urandom_range(0, 1) == 1, ra, $urandom, $urandom_range(0, 2) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
